// File: rtl/mtx_seq.sv
// mtx_seq: program sequencer for mtx_unit.
//
// Holds a DEPTH-word VLIW program store and issues one vliw_inst_t per cycle
// over an inclusive [start_pc, end_pc] range (wrapping modulo DEPTH). Stall
// cycles become NOP bubbles so no word executes twice. Status returned by the
// unit is tracked through a 2-deep issue pipe, so err/ovf line up with the
// word that caused them.
//
// Build option: MTX_SEQ_LOOP_EN enables multi-pass looping (loop_cnt passes).
// Without it every run is a single pass and loop_cnt is ignored.
//
// Ports (mtx_seq):
//   clk, rst_n              clock, async active-low reset
//   prog_we/addr/wdata      program store write (IDLE only)
//   start, start_pc, end_pc run request and range (IDLE or DONE)
//   loop_cnt                pass count, 0 behaves as 1
//   abort                   synchronous abort to IDLE, beats start and stall
//   stall                   issue a bubble this cycle
//   st_in                   status from mtx_unit
//   vliw_inst, issue        registered instruction and its valid
//   pc                      current fetch pc
//   busy, done              RUN/DRAIN, one-cycle completion pulse
//   err, ovf                sticky invalid-opcode / overflow flags

package mtx_types;
    localparam int NUM_LANES = 4;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LD    = 4'd1;
    localparam logic [3:0] OP_ST    = 4'd2;
    localparam logic [3:0] OP_MVMUL = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_MAX   = OP_ADD;  // anything above is invalid

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] dst;
        logic [3:0] src_a;
        logic [3:0] src_b;
    } slot_t;

    typedef slot_t [NUM_LANES-1:0] vliw_inst_t;

    typedef struct packed {
        logic inv;
        logic of;
    } status_t;
endpackage

// Per-slot column of the program store plus its output register.
// The output register loads the addressed slot on issue and clears to NOP
// otherwise.
module mtx_seq_lane
    import mtx_types::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  slot_t         wdata,
    input  logic [AW-1:0] raddr,
    input  logic          ld,
    output slot_t         q
);
    slot_t mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            q <= '0;
        end else begin
            if (we) mem[waddr] <= wdata;
            q <= ld ? mem[raddr] : '0;
        end
    end
endmodule

module mtx_seq
    import mtx_types::*;
#(
    parameter  int DEPTH = 16,
    parameter  int CNT_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  vliw_inst_t       prog_wdata,
    input  logic             start,
    input  logic [AW-1:0]    start_pc,
    input  logic [AW-1:0]    end_pc,
    input  logic [CNT_W-1:0] loop_cnt,
    input  logic             abort,
    input  logic             stall,
    input  status_t          st_in,
    output vliw_inst_t       vliw_inst,
    output logic             issue,
    output logic [AW-1:0]    pc,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             ovf
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e        state, state_nxt;
    logic [AW-1:0] pc_nxt, spc, epc;
    logic          issue_nxt, done_nxt, accept, wrap, more_passes;
    logic          mem_we, inv_hit;
    // vld_pipe[1]: word on vliw_inst now; vld_pipe[2]: word the unit is
    // executing now, whose status is on st_in.
    logic [2:1]    vld_pipe;

    assign issue   = vld_pipe[1];
    assign busy    = (state == S_RUN) || (state == S_DRAIN);
    assign mem_we  = prog_we && (state == S_IDLE);
    assign inv_hit = vld_pipe[2] && st_in.inv;

`ifdef MTX_SEQ_LOOP_EN
    logic [CNT_W-1:0] rem;

    assign more_passes = rem > CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rem <= '0;
        else if (accept) rem <= (loop_cnt == '0) ? CNT_W'(1) : loop_cnt;
        else if (wrap)   rem <= rem - CNT_W'(1);
    end
`else
    logic unused_loop;

    assign more_passes = 1'b0;
    assign unused_loop = ^{loop_cnt, wrap};
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        issue_nxt = 1'b0;
        done_nxt  = 1'b0;
        accept    = 1'b0;
        wrap      = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        accept    = 1'b1;
                        state_nxt = S_RUN;
                        pc_nxt    = start_pc;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                S_RUN: begin
                    // An invalid opcode stops fetch on the edge it is seen.
                    if (inv_hit) begin
                        state_nxt = S_DRAIN;
                    end else if (!stall) begin
                        issue_nxt = 1'b1;
                        if (pc != epc) begin
                            pc_nxt = pc + 1'b1;
                        end else if (more_passes) begin
                            pc_nxt = spc;
                            wrap   = 1'b1;
                        end else begin
                            state_nxt = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // With nothing on vliw_inst, the last in-flight status is
                    // sampled on this edge, so the pipe is empty afterwards.
                    if (!vld_pipe[1]) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            spc      <= '0;
            epc      <= '0;
            vld_pipe <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            vld_pipe <= abort ? 2'b00 : {vld_pipe[1], issue_nxt};
            done     <= done_nxt;
            if (accept) begin
                spc <= start_pc;
                epc <= end_pc;
                err <= 1'b0;
                ovf <= 1'b0;
            end else if (!abort && vld_pipe[2]) begin
                if (st_in.inv) err <= 1'b1;
                if (st_in.of)  ovf <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mtx_seq_lane #(.DEPTH(DEPTH)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (mem_we),
            .waddr (prog_addr),
            .wdata (prog_wdata[i]),
            .raddr (pc),
            .ld    (issue_nxt),
            .q     (vliw_inst[i])
        );
    end
endmodule
